mem_access_unit: RTL and testbench

- Parametrised load/store engine between CPU execute stage and N memory ports (local, north, further neighbours).
- Computes effective address r2+imm and decodes the target port from the address top bits.
- Issues a registered read/write request, waits on that port's ready with a timeout, then returns load data on r1_out.
- Stalls the pipeline through mem_busy.

---
 rtl/mem_pkg.sv | 30 +++
 rtl/mem_port_decode.sv | 29 ++
 rtl/mem_access_unit.sv | 174 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
//------------------------------------------------------------------------------
// mem_pkg
// Shared types and constants for the memory access unit.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mem_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 32;

    localparam int PORT_LOCAL = 0;
    localparam int PORT_NORTH = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } mem_state_e;

    // A disabled timeout still needs a legal one-bit counter.
    function automatic int cnt_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_port_decode.sv
//------------------------------------------------------------------------------
// mem_port_decode
// Port select to one-hot read/write request plus invalid-port flag.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_port_decode #(
    parameter int N_PORTS = 2,
    parameter int SEL_W   = 1
) (
    input  logic [SEL_W-1:0]   i_sel,
    input  logic               i_load,
    input  logic               i_store,
    output logic [N_PORTS-1:0] o_read,
    output logic [N_PORTS-1:0] o_write,
    output logic               o_port_invalid
);

    for (genvar p = 0; p < N_PORTS; p++) begin : g_port
        assign o_read[p]  = i_load  & (i_sel == SEL_W'(p));
        assign o_write[p] = i_store & (i_sel == SEL_W'(p));
    end

    assign o_port_invalid = ({1'b0, i_sel} >= (SEL_W + 1)'(N_PORTS));

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
//------------------------------------------------------------------------------
// mem_access_unit
// Load/store engine: effective address, port decode, request, ready/timeout.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_access_unit
    import mem_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int N_PORTS = 2,
    parameter int SEL_W   = 1,
    parameter int TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      op_valid,
    input  logic                      op_load,
    input  logic                      op_store,
    input  logic [DATA_W-1:0]         imm,
    input  logic [DATA_W-1:0]         r2,
    input  logic [DATA_W-1:0]         r1_in,
    input  logic [N_PORTS*DATA_W-1:0] mem_rdata,
    input  logic [N_PORTS-1:0]        mem_rdy,
    output logic [DATA_W-1:0]         r1_out,
    output logic [ADDR_W-1:0]         addr,
    output logic [DATA_W-1:0]         wdata,
    output logic [N_PORTS-1:0]        mem_read,
    output logic [N_PORTS-1:0]        mem_write,
    output logic                      mem_busy,
    output logic                      ld_done,
    output logic                      st_done,
    output logic                      mem_err
);

    localparam int CNT_W = cnt_width(TIMEOUT);

    mem_state_e          state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [N_PORTS-1:0]  mem_read_q, mem_read_d;
    logic [N_PORTS-1:0]  mem_write_q, mem_write_d;
    logic                is_load_q, is_load_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [DATA_W-1:0]   w_sum;
    logic [ADDR_W-1:0]   w_eff_addr;
    logic [SEL_W-1:0]    w_sel;
    logic [N_PORTS-1:0]  w_dec_read;
    logic [N_PORTS-1:0]  w_dec_write;
    logic                w_port_invalid;
    logic [N_PORTS-1:0]  w_req_mask;
    logic                w_rdy_hit;
    logic [DATA_W-1:0]   w_rdata_sel;
    logic                w_timeout;

    assign w_sum      = r2 + imm;
    assign w_eff_addr = ADDR_W'(w_sum);
    assign w_sel      = w_eff_addr[ADDR_W-1 -: SEL_W];

    mem_port_decode #(
        .N_PORTS (N_PORTS),
        .SEL_W   (SEL_W)
    ) u_decode (
        .i_sel          (w_sel),
        .i_load         (op_load & ~op_store),
        .i_store        (op_store & ~op_load),
        .o_read         (w_dec_read),
        .o_write        (w_dec_write),
        .o_port_invalid (w_port_invalid)
    );

    // Only the port currently being addressed may complete the request.
    assign w_req_mask = mem_read_q | mem_write_q;
    assign w_rdy_hit  = |(mem_rdy & w_req_mask);
    assign w_timeout  = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        w_rdata_sel = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            if (w_req_mask[p]) begin
                w_rdata_sel = w_rdata_sel | mem_rdata[p*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        data_d      = data_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        is_load_d   = is_load_q;
        cnt_d       = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (op_valid && (op_load || op_store)) begin
                    if (op_load && op_store) begin
                        state_d = ST_ERR;
                    end else begin
                        addr_d    = w_eff_addr;
                        wdata_d   = r1_in;
                        is_load_d = op_load;
                        cnt_d     = '0;
                        if (w_port_invalid) begin
                            state_d = ST_ERR;
                        end else begin
                            state_d     = ST_REQ;
                            mem_read_d  = w_dec_read;
                            mem_write_d = w_dec_write;
                        end
                    end
                end
            end
            ST_REQ: begin
                cnt_d = cnt_q + 1'b1;
                if (w_rdy_hit) begin
                    if (is_load_q) begin
                        data_d = w_rdata_sel;
                    end
                    state_d     = ST_DONE;
                    mem_read_d  = '0;
                    mem_write_d = '0;
                end else if (w_timeout) begin
                    state_d     = ST_ERR;
                    mem_read_d  = '0;
                    mem_write_d = '0;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            data_q      <= '0;
            mem_read_q  <= '0;
            mem_write_q <= '0;
            is_load_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            data_q      <= data_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            is_load_q   <= is_load_d;
            cnt_q       <= cnt_d;
        end
    end

    assign addr      = addr_q;
    assign wdata     = wdata_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_busy  = (state_q == ST_REQ);
    assign ld_done   = (state_q == ST_DONE) &&  is_load_q;
    assign st_done   = (state_q == ST_DONE) && !is_load_q;
    assign mem_err   = (state_q == ST_ERR);
    assign r1_out    = ld_done ? data_q : r1_in;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
//------------------------------------------------------------------------------
// tb_mem_access_unit
// Directed bench: default 2-port unit and a 3-port unit with TIMEOUT=4.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_access_unit;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Instance A: defaults (2 ports, TIMEOUT=255)
    logic        a_op_valid = 0, a_op_load = 0, a_op_store = 0;
    logic [31:0] a_imm = 0, a_r2 = 0, a_r1_in = 0;
    logic [63:0] a_rdata = 0;
    logic [1:0]  a_rdy = 0;
    logic [31:0] a_r1_out, a_addr, a_wdata;
    logic [1:0]  a_rd, a_wr;
    logic        a_busy, a_ld, a_st, a_err;

    // Instance B: 3 ports, SEL_W=2, TIMEOUT=4
    logic        b_op_valid = 0, b_op_load = 0, b_op_store = 0;
    logic [31:0] b_imm = 0, b_r2 = 0, b_r1_in = 0;
    logic [95:0] b_rdata = 0;
    logic [2:0]  b_rdy = 0;
    logic [31:0] b_r1_out, b_addr, b_wdata;
    logic [2:0]  b_rd, b_wr;
    logic        b_busy, b_ld, b_st, b_err;

    int n_checks = 0;
    int n_errors = 0;

    mem_access_unit u_dut_a (
        .clk(clk), .rst(rst), .op_valid(a_op_valid), .op_load(a_op_load),
        .op_store(a_op_store), .imm(a_imm), .r2(a_r2), .r1_in(a_r1_in),
        .mem_rdata(a_rdata), .mem_rdy(a_rdy), .r1_out(a_r1_out), .addr(a_addr),
        .wdata(a_wdata), .mem_read(a_rd), .mem_write(a_wr), .mem_busy(a_busy),
        .ld_done(a_ld), .st_done(a_st), .mem_err(a_err)
    );

    mem_access_unit #(.N_PORTS(3), .SEL_W(2), .TIMEOUT(4)) u_dut_b (
        .clk(clk), .rst(rst), .op_valid(b_op_valid), .op_load(b_op_load),
        .op_store(b_op_store), .imm(b_imm), .r2(b_r2), .r1_in(b_r1_in),
        .mem_rdata(b_rdata), .mem_rdy(b_rdy), .r1_out(b_r1_out), .addr(b_addr),
        .wdata(b_wdata), .mem_read(b_rd), .mem_write(b_wr), .mem_busy(b_busy),
        .ld_done(b_ld), .st_done(b_st), .mem_err(b_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        check("rst_addr",  a_addr, 0);
        check("rst_wdata", a_wdata, 0);
        check("rst_req",   {a_rd, a_wr}, 0);
        check("rst_flags", {a_busy, a_ld, a_st, a_err}, 0);
        check("rst_b_req", {b_rd, b_wr, b_busy, b_err}, 0);
        #10 rst = 1'b1;
        tick();

        // Local load, ready in the third request cycle
        a_r2 = 32'h0000_0100; a_imm = 32'h10; a_r1_in = 32'hAAAA_0000;
        a_op_valid = 1; a_op_load = 1;
        tick();
        a_op_valid = 0; a_op_load = 0;
        check("ld_addr", a_addr, 32'h0000_0110);
        for (int c = 1; c <= 3; c++) begin
            check("ld_req", a_rd, 2'b01);
            check("ld_busy", {a_busy, a_ld}, 2'b10);
            if (c == 3) begin
                a_rdy = 2'b01; a_rdata[31:0] = 32'hDEAD_BEEF;
            end
            if (c < 3) tick();
        end
        tick();
        a_rdy = 0;
        check("ld_done", a_ld, 1);
        check("ld_r1_out", a_r1_out, 32'hDEAD_BEEF);
        check("ld_after", {a_busy, a_rd}, 0);
        tick();
        check("ld_pulse_end", a_ld, 0);
        check("ld_passthru", a_r1_out, 32'hAAAA_0000);

        // North store with immediate ready
        a_r2 = 32'h8000_0000; a_imm = 32'h4; a_r1_in = 32'h1234_5678;
        a_op_valid = 1; a_op_store = 1; a_rdy = 2'b10;
        tick();
        a_op_valid = 0; a_op_store = 0;
        check("st_req", {a_wr, a_rd}, 4'b1000);
        check("st_wdata", a_wdata, 32'h1234_5678);
        check("st_addr", a_addr, 32'h8000_0004);
        tick();
        a_rdy = 0;
        check("st_done", {a_st, a_ld, a_busy, a_wr}, 5'b10000);
        check("st_r1_out", a_r1_out, 32'h1234_5678);
        tick();
        check("st_pulse_end", a_st, 0);

        // Address wrap to port 0, with ready pulses on the wrong port
        a_r2 = 32'hFFFF_FFFC; a_imm = 32'h8; a_r1_in = 32'h5555_5555;
        a_op_valid = 1; a_op_load = 1;
        tick();
        a_op_valid = 0; a_op_load = 0;
        check("wrap_addr", a_addr, 32'h0000_0004);
        check("wrap_req", a_rd, 2'b01);
        a_rdy = 2'b10; a_rdata = {32'h1111_1111, 32'h0BAD_F00D};
        tick();
        a_rdy = 0;
        tick();
        a_rdy = 2'b10;
        tick();
        check("wrong_rdy_busy", {a_busy, a_ld, a_rd}, 4'b1001);
        a_rdy = 2'b01;
        tick();
        a_rdy = 0;
        check("wrap_ld_done", a_ld, 1);
        check("wrap_r1_out", a_r1_out, 32'h0BAD_F00D);
        tick();

        // Illegal op, then op_valid with neither load nor store
        a_op_valid = 1; a_op_load = 1; a_op_store = 1;
        tick();
        a_op_load = 0; a_op_store = 0;
        check("illegal_err", {a_err, a_busy, a_rd, a_wr}, 6'b100000);
        check("illegal_r1", a_r1_out, 32'h5555_5555);
        tick();
        a_op_valid = 0;
        check("noop_idle", {a_err, a_busy, a_rd, a_wr}, 0);

        // Reset in the middle of a request
        a_r2 = 32'h40; a_imm = 0; a_op_valid = 1; a_op_load = 1;
        tick();
        a_op_valid = 0; a_op_load = 0;
        check("mid_req", a_rd, 2'b01);
        rst = 1'b0;
        #1;
        check("async_drop", {a_rd, a_busy}, 0);
        tick();
        check("rst_no_pulse", {a_ld, a_st, a_err}, 0);
        rst = 1'b1;
        tick();
        check("post_rst_idle", {a_busy, a_rd, a_ld}, 0);

        // Timeout on instance B: four request cycles then err
        b_r2 = 32'h0000_0100; b_imm = 0; b_r1_in = 32'h7777_7777;
        b_op_valid = 1; b_op_load = 1;
        tick();
        b_op_valid = 0; b_op_load = 0;
        for (int c = 1; c <= 4; c++) begin
            check("to_req", {b_rd, b_busy, b_err}, 5'b00110);
            if (c < 4) tick();
        end
        tick();
        check("to_err", {b_err, b_busy, b_rd, b_ld}, 6'b100000);
        tick();
        check("to_err_end", b_err, 0);

        // Invalid port: top bits 2'b11 with three ports
        b_r2 = 32'hC000_0000; b_op_valid = 1; b_op_load = 1;
        tick();
        b_op_valid = 0; b_op_load = 0;
        check("badport_err", {b_err, b_busy, b_rd, b_wr}, 8'b1000_0000);
        check("badport_r1", b_r1_out, 32'h7777_7777);
        tick();
        check("badport_end", b_err, 0);

        // Store to port 2 on instance B
        b_r2 = 32'h8000_0000; b_r1_in = 32'hCAFE_F00D;
        b_op_valid = 1; b_op_store = 1;
        tick();
        b_op_valid = 0; b_op_store = 0;
        check("p2_req", {b_wr, b_rd}, 6'b100000);
        check("p2_wdata", b_wdata, 32'hCAFE_F00D);
        b_rdy = 3'b100;
        tick();
        b_rdy = 0;
        check("p2_st_done", {b_st, b_busy, b_wr}, 5'b10000);
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
